pc_register: RTL and testbench
==============================

Name: pc_register

Overview:
- Program counter register for the P5 pipelined MIPS-style CPU, sitting at the head of the fetch (IF) stage.
- Holds the current instruction address and loads the next-PC value, selected upstream, on every rising clock edge.
- Also supplies sequential-address helpers and a fetch-address error flag for the instruction memory and the link logic.

Parameters:
- RESET_ADDR, 32'h0000_3000, value PC_now takes while reset is asserted.
- IM_BASE, 32'h0000_3000, lowest valid instruction-memory byte address.
- IM_SIZE, 32'h0000_1000, instruction-memory size in bytes; the valid range is [IM_BASE, IM_BASE+IM_SIZE).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset; asynchronous, active-low. clr=0 forces reset.
- in  input  32  next-PC value from the upstream next-PC mux.
- PC_now  output  32  current PC, registered.
- PC_plus4  output  32  PC_now+4, combinational.
- PC_plus8  output  32  PC_now+8, combinational; the link address for jal/jalr.
- addr_err  output  1  fetch-address error, combinational.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - When clr falls to 0, PC_now becomes RESET_ADDR immediately, without waiting for a clock edge.
  - PC_now stays at RESET_ADDR while clr=0, whatever clk and in are doing.
  - The derived outputs therefore read PC_plus4=32'h0000_3004, PC_plus8=32'h0000_3008 and addr_err=0 (with default parameters).
- Normal operation:
  - On each rising clk edge with clr=1, PC_now <= in. Latency is one cycle.
  - There is no enable or stall input: the register loads every cycle. Stalling is done upstream by feeding PC_now back on in.
- Reset release:
  - The first load happens on the first rising edge after clr returns to 1.
  - An edge that coincides with clr=0 does not load.
- Reset mid-operation: an asynchronous clr assertion overrides any pending load. PC_now returns to RESET_ADDR within the same cycle.
- Alignment: in is loaded verbatim, including bits [1:0]. The register never silently re-aligns.
- Arithmetic:
  - PC_plus4 and PC_plus8 are unsigned 32-bit sums.
  - Carry out is discarded, so they wrap modulo 2^32 (e.g. 32'hFFFF_FFFC -> PC_plus4=0, PC_plus8=4).
- addr_err = 1 when any of these holds:
  - PC_now[1:0] != 0;
  - PC_now < IM_BASE;
  - PC_now >= IM_BASE+IM_SIZE, using a 33-bit compare so IM_BASE+IM_SIZE cannot overflow.
  - addr_err is purely combinational from PC_now. It has no effect on the register, which keeps loading.
- Boundaries (default parameters):
  - PC_now=32'h0000_3FFC is valid (addr_err=0).
  - PC_now=32'h0000_4000 and 32'h0000_2FFC both give addr_err=1.
- No X propagation from reset: all outputs are defined while clr=0, even if in is X.

Test Plan:
- Hold clr=0, in=0, toggle clk for 100 ns -> PC_now stays 32'h0000_3000, PC_plus4=32'h0000_3004, PC_plus8=32'h0000_3008, addr_err=0.
- Release clr=1 and drive in=3004, 3008, 300C on successive rising edges -> PC_now follows with one-cycle latency; no change occurs between edges.
- With PC_now=32'h0000_3010, assert clr=0 mid-cycle (no edge) -> PC_now becomes 32'h0000_3000 immediately. Edges during reset with in=32'h0000_5000 do not load.
- Load in=32'h0000_3FFC, then 32'h0000_4000, then 32'h0000_2FFC -> addr_err = 0, 1, 1 respectively.
- Load in=32'h0000_3002 -> PC_now=32'h0000_3002 (not re-aligned), addr_err=1.
- Load in=32'hFFFF_FFFC -> PC_plus4=32'h0000_0000, PC_plus8=32'h0000_0004, addr_err=1.

Source files
------------

// File: rtl/pc_register.sv
// Program counter for the IF stage: loads next-PC every rising edge and
// exposes PC+4, PC+8 (link address) and a fetch-address error flag.
module pc_register #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] in,
  output logic [31:0] PC_now,
  output logic [31:0] PC_plus4,
  output logic [31:0] PC_plus8,
  output logic        addr_err
);

  logic [31:0] pc_r;
  logic [31:0] plus4_s;
  logic [31:0] plus8_s;
  logic        err_s;

  // The end address is formed in 33 bits so base+size can never wrap.
  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    logic [32:0] im_end;
    logic        misaligned;
    logic        below;
    logic        above;
    im_end     = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    misaligned = (addr[1:0] != 2'b00);
    below      = (addr < IM_BASE);
    above      = ({1'b0, addr} >= im_end);
    return misaligned | below | above;
  endfunction

  // PC state: async clear to the reset vector, otherwise load in verbatim.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_r <= RESET_ADDR;
    end else begin
      pc_r <= in;
    end
  end

  // Sequential-address helpers and fetch check, all derived from pc_r only.
  always_comb begin
    plus4_s = 32'h0000_0000;
    plus8_s = 32'h0000_0000;
    err_s   = 1'b0;
    plus4_s = pc_r + 32'd4;
    plus8_s = pc_r + 32'd8;
    err_s   = fetch_addr_bad(pc_r);
  end

  assign PC_now   = pc_r;
  assign PC_plus4 = plus4_s;
  assign PC_plus8 = plus8_s;
  assign addr_err = err_s;

endmodule

// File: tb/tb_pc_register.sv
// Directed self-checking bench for pc_register.
module tb_pc_register;

  logic        clk;
  logic        clr;
  logic [31:0] in;
  logic [31:0] PC_now;
  logic [31:0] PC_plus4;
  logic [31:0] PC_plus8;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  pc_register dut (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .PC_now   (PC_now),
    .PC_plus4 (PC_plus4),
    .PC_plus8 (PC_plus8),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    clr = 1'b0;
    in  = 32'h0000_0000;
    #100;
    checks++;
    if (PC_now !== 32'h0000_3000) begin
      errors++; $display("FAIL reset_pc got=%h exp=%h", PC_now, 32'h0000_3000);
    end
    checks++;
    if (PC_plus4 !== 32'h0000_3004) begin
      errors++; $display("FAIL reset_plus4 got=%h exp=%h", PC_plus4, 32'h0000_3004);
    end
    checks++;
    if (PC_plus8 !== 32'h0000_3008) begin
      errors++; $display("FAIL reset_plus8 got=%h exp=%h", PC_plus8, 32'h0000_3008);
    end
    checks++;
    if (addr_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b exp=%b", addr_err, 1'b0);
    end
    // Unknown next-PC during reset must not leak into any output.
    in = 32'hxxxx_xxxx;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({PC_now, PC_plus4, PC_plus8, addr_err} !== {32'h0000_3000, 32'h0000_3004, 32'h0000_3008, 1'b0}) begin
      errors++; $display("FAIL reset_x_in got=%h/%h/%h/%b exp=3000/3004/3008/0", PC_now, PC_plus4, PC_plus8, addr_err);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] vec [3];
    vec[0] = 32'h0000_3004; vec[1] = 32'h0000_3008; vec[2] = 32'h0000_300C;
    @(negedge clk);
    clr = 1'b1;
    in  = vec[0];
    #2;
    checks++;
    if (PC_now !== 32'h0000_3000) begin
      errors++; $display("FAIL release_no_load got=%h exp=%h", PC_now, 32'h0000_3000);
    end
    for (int i = 0; i < 3; i++) begin
      in = vec[i];
      @(posedge clk);
      #1;
      checks++;
      if (PC_now !== vec[i]) begin
        errors++; $display("FAIL seq_load%0d got=%h exp=%h", i, PC_now, vec[i]);
      end
      checks++;
      if (PC_plus8 !== vec[i] + 32'd8) begin
        errors++; $display("FAIL seq_plus8_%0d got=%h exp=%h", i, PC_plus8, vec[i] + 32'd8);
      end
      in = 32'h0000_7777;
      @(negedge clk);
      checks++;
      if (PC_now !== vec[i]) begin
        errors++; $display("FAIL seq_hold%0d got=%h exp=%h", i, PC_now, vec[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    in = 32'h0000_3010;
    @(posedge clk);
    #1;
    checks++;
    if (PC_now !== 32'h0000_3010) begin
      errors++; $display("FAIL pre_async got=%h exp=%h", PC_now, 32'h0000_3010);
    end
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if (PC_now !== 32'h0000_3000) begin
      errors++; $display("FAIL async_clear got=%h exp=%h", PC_now, 32'h0000_3000);
    end
    in = 32'h0000_5000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (PC_now !== 32'h0000_3000) begin
      errors++; $display("FAIL reset_no_load got=%h exp=%h", PC_now, 32'h0000_3000);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_boundaries();
    logic [31:0] addr [3];
    logic        exp_err [3];
    addr[0] = 32'h0000_3FFC; exp_err[0] = 1'b0;
    addr[1] = 32'h0000_4000; exp_err[1] = 1'b1;
    addr[2] = 32'h0000_2FFC; exp_err[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = addr[i];
      @(posedge clk);
      #1;
      checks++;
      if (PC_now !== addr[i]) begin
        errors++; $display("FAIL bound_pc%0d got=%h exp=%h", i, PC_now, addr[i]);
      end
      checks++;
      if (addr_err !== exp_err[i]) begin
        errors++; $display("FAIL bound_err%0d got=%b exp=%b", i, addr_err, exp_err[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    in = 32'h0000_3002;
    @(posedge clk);
    #1;
    checks++;
    if (PC_now !== 32'h0000_3002) begin
      errors++; $display("FAIL misalign_pc got=%h exp=%h", PC_now, 32'h0000_3002);
    end
    checks++;
    if (addr_err !== 1'b1) begin
      errors++; $display("FAIL misalign_err got=%b exp=%b", addr_err, 1'b1);
    end
    checks++;
    if (PC_plus4 !== 32'h0000_3006) begin
      errors++; $display("FAIL misalign_plus4 got=%h exp=%h", PC_plus4, 32'h0000_3006);
    end
  endtask

  task automatic test_wrap();
    in = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    checks++;
    if (PC_plus4 !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_plus4 got=%h exp=%h", PC_plus4, 32'h0000_0000);
    end
    checks++;
    if (PC_plus8 !== 32'h0000_0004) begin
      errors++; $display("FAIL wrap_plus8 got=%h exp=%h", PC_plus8, 32'h0000_0004);
    end
    checks++;
    if (addr_err !== 1'b1) begin
      errors++; $display("FAIL wrap_err got=%b exp=%b", addr_err, 1'b1);
    end
    // Back to a valid address: error must clear and the load must still happen.
    in = 32'h0000_3100;
    @(posedge clk);
    #1;
    checks++;
    if ({PC_now, addr_err} !== {32'h0000_3100, 1'b0}) begin
      errors++; $display("FAIL recover got=%h/%b exp=00003100/0", PC_now, addr_err);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_async_reset();
    test_boundaries();
    test_misaligned();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
